sprite_pixel_ctrl: RTL

- Per-pixel sequencer that shares one sprite ROM and one 16-entry sprite palette between two tank sprites (0 = player, 1 = enemy).
- Sits between the VGA controller (DrawX/DrawY) and the colour mapper.
- For each pixel it hit-tests both sprites, arbitrates by fixed priority, and issues the ROM read. It then steers the returned 4-bit index into the palette, applies the transparency key and registers the final 12-bit RGB.
- Sprite positions and frames are shadowed once per video frame to prevent tearing.

---
 rtl/sprite_pixel_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/sprite_pixel_ctrl.sv
// Two-sprite pixel sequencer: per-frame position shadowing, hit test with
// fixed priority, one shared ROM read per pixel, palette steering,
// transparency keying and a registered 12-bit RGB output.
module sprite_pixel_ctrl #(
  parameter int         SPR_W      = 32,
  parameter int         SPR_H      = 32,
  parameter int         FRAMES     = 4,
  parameter int         ADDR_W     = 13,
  parameter logic [3:0] TRANSP_IDX = 4'd0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_start,
  input  logic              pix_en,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        s0_x,
  input  logic [9:0]        s1_x,
  input  logic [9:0]        s0_y,
  input  logic [9:0]        s1_y,
  input  logic [1:0]        s0_frame,
  input  logic [1:0]        s1_frame,
  input  logic              s0_en,
  input  logic              s1_en,
  input  logic [11:0]       bg_rgb,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        pal_index,
  input  logic [11:0]       pal_rgb,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              rgb_valid
);

  // Live sprite inputs gathered into arrays, index 0 = player, 1 = enemy
  logic [9:0] live_x [2];
  logic [9:0] live_y [2];
  logic [1:0] live_frame [2];
  logic       live_en [2];

  assign live_x[0]     = s0_x;
  assign live_x[1]     = s1_x;
  assign live_y[0]     = s0_y;
  assign live_y[1]     = s1_y;
  assign live_frame[0] = s0_frame;
  assign live_frame[1] = s1_frame;
  assign live_en[0]    = s0_en;
  assign live_en[1]    = s1_en;

  // Shadow copies used for rendering, refreshed only at frame_start
  logic [9:0] sh_x_reg [2];
  logic [9:0] sh_y_reg [2];
  logic [1:0] sh_frame_reg [2];
  logic       sh_en_reg [2];

  // Per-sprite hit flags and candidate ROM addresses
  logic              hit [2];
  logic [9:0]        off_x [2];
  logic [9:0]        off_y [2];
  logic [ADDR_W-1:0] cand_addr [2];

  // Pixel coordinates widened so x+SPR_W near 1023 does not wrap
  logic [10:0] draw_x_ext;
  logic [10:0] draw_y_ext;

  assign draw_x_ext = {1'b0, DrawX};
  assign draw_y_ext = {1'b0, DrawY};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sprite
      // Latch live position/frame/enable at the start of vertical blank
      always_ff @(posedge Clk) begin
        if (!Reset_n) begin
          sh_x_reg[gi]     <= '0;
          sh_y_reg[gi]     <= '0;
          sh_frame_reg[gi] <= '0;
          sh_en_reg[gi]    <= 1'b0;
        end else if (frame_start) begin
          sh_x_reg[gi]     <= live_x[gi];
          sh_y_reg[gi]     <= live_y[gi];
          sh_frame_reg[gi] <= live_frame[gi];
          sh_en_reg[gi]    <= live_en[gi];
        end
      end

      assign hit[gi] = sh_en_reg[gi]
                    && (draw_x_ext >= {1'b0, sh_x_reg[gi]})
                    && (draw_x_ext <  ({1'b0, sh_x_reg[gi]} + 11'(SPR_W)))
                    && (draw_y_ext >= {1'b0, sh_y_reg[gi]})
                    && (draw_y_ext <  ({1'b0, sh_y_reg[gi]} + 11'(SPR_H)));

      assign off_x[gi] = DrawX - sh_x_reg[gi];
      assign off_y[gi] = DrawY - sh_y_reg[gi];

      // Offsets are only meaningful on a hit, when they lie inside the sprite
      assign cand_addr[gi] = ADDR_W'(((gi * FRAMES + int'(sh_frame_reg[gi])) * SPR_H
                                      + int'(off_y[gi])) * SPR_W + int'(off_x[gi]));
    end
  endgenerate

  // Pipeline state
  logic              v1_reg;
  logic              hit1_reg;
  logic              v2_reg;
  logic              hit2_reg;
  logic [ADDR_W-1:0] rom_addr_reg;
  logic [ADDR_W-1:0] rom_addr_next;
  logic              any_hit;
  logic [11:0]       rgb_reg;
  logic [11:0]       rgb_next;
  logic              rgb_valid_reg;

  // Fixed priority: sprite 0 wins; address holds when nothing is fetched
  always_comb begin
    any_hit       = hit[0] || hit[1];
    rom_addr_next = rom_addr_reg;
    if (pix_en) begin
      if (hit[0]) begin
        rom_addr_next = cand_addr[0];
      end else if (hit[1]) begin
        rom_addr_next = cand_addr[1];
      end
    end
  end

  // Stage 1: register hit and issue the ROM read
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      v1_reg       <= 1'b0;
      hit1_reg     <= 1'b0;
      rom_addr_reg <= '0;
    end else begin
      v1_reg       <= pix_en;
      hit1_reg     <= pix_en && any_hit;
      rom_addr_reg <= rom_addr_next;
    end
  end

  // Stage 2: ROM data arrives alongside these flags
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      v2_reg   <= 1'b0;
      hit2_reg <= 1'b0;
    end else begin
      v2_reg   <= v1_reg;
      hit2_reg <= hit1_reg;
    end
  end

  assign pal_index = (v2_reg && hit2_reg) ? rom_data : 4'd0;

  // Transparent key never falls through to the other sprite: background wins
  always_comb begin
    rgb_next = bg_rgb;
    if (hit2_reg && (rom_data != TRANSP_IDX)) begin
      rgb_next = pal_rgb;
    end
  end

  // Stage 3: register final colour; colour holds across idle cycles
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rgb_reg       <= '0;
      rgb_valid_reg <= 1'b0;
    end else begin
      rgb_valid_reg <= v2_reg;
      if (v2_reg) begin
        rgb_reg <= rgb_next;
      end
    end
  end

  assign rom_addr  = rom_addr_reg;
  assign red       = rgb_reg[11:8];
  assign green     = rgb_reg[7:4];
  assign blue      = rgb_reg[3:0];
  assign rgb_valid = rgb_valid_reg;

endmodule
